uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter GAP_BITS, default 1: idle bit periods (b_tick pulses) inserted after every frame (0..15).
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 b_tick  input  1  one-clk baud pulse from the shared baud generator.
REQ-006 req  input  N_REQ  level request per requester.
REQ-007 req_data  input  8*N_REQ  packed bytes; requester i uses bits [8i+7:8i].
REQ-008 tx_busy  input  1  serializer frame-in-progress flag; high from the cycle after tx_start until the stop bit ends.
REQ-009 ack  output  N_REQ  one-clk pulse to requester i when its byte is captured.
REQ-010 tx_start  output  1  one-clk launch pulse to the serializer.
REQ-011 tx_data  output  8  registered byte to the serializer, stable from tx_start until the next capture.
REQ-012 grant_id  output  clog2(N_REQ)  index of the requester most recently granted.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The block SHALL implement the states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE and GAP.
REQ-015 In IDLE with any req bit high, the block SHALL select one requester round-robin, starting the search at the pointer and wrapping from N_REQ-1 to 0.
REQ-016 On selection, at the same clock edge the block SHALL capture req_data of the winner into tx_data, load grant_id, pulse ack[winner] for exactly one cycle, and enter LAUNCH.
REQ-017 The round-robin pointer SHALL be set to (winner+1) mod N_REQ on every grant.
REQ-018 In LAUNCH, tx_start SHALL be high for exactly one cycle, after which the state SHALL be WAIT_BUSY.
REQ-019 In WAIT_BUSY the block SHALL hold until tx_busy=1, then enter WAIT_DONE.
REQ-020 In WAIT_DONE the block SHALL hold until tx_busy=0, then enter GAP with the gap counter cleared.
REQ-021 In GAP the block SHALL count b_tick pulses and return to IDLE on the GAP_BITS-th pulse; with GAP_BITS=0 it SHALL return to IDLE on the next cycle.
REQ-022 Requests SHALL be ignored outside IDLE; a req dropped before its ack SHALL never be granted, and no ack SHALL be issued for it.
REQ-023 A requester holding req high after its ack SHALL be treated as a new request, subject to round-robin order.
REQ-024 Latency from req rising in IDLE (no contention) to tx_start SHALL be exactly 2 clk cycles: ack on edge 1, tx_start high in the following cycle.
REQ-025 tx_data SHALL change only at a grant edge.
REQ-026 At most one ack bit SHALL be high in any cycle, and tx_start and ack SHALL never be high in the same cycle.

Reset
REQ-027 On rst the block SHALL enter IDLE and clear ack, tx_start, tx_data, grant_id, busy, the pointer and the gap counter to 0, independent of clk.
REQ-028 Reset asserted mid-frame SHALL abort the sequence without issuing an ack or tx_start; after release, arbitration SHALL restart at requester 0.

Structure
REQ-029 State encodings and the default GAP_BITS value SHALL reside in the shared package uart_pkg.
REQ-030 Round-robin selection SHALL be one combinational sub-module, rr_select (inputs req and pointer; outputs valid and index).

Verification
REQ-031 Single request: N_REQ=4, req=4'b0100, req_data byte2=8'h41 -> ack[2] pulses, tx_start follows 1 cycle later, tx_data=8'h41, grant_id=2.
REQ-032 Contention fairness: req=4'b1111 held with the pointer at 0 and byte i=8'h30+i -> grant order 0,1,2,3,0 and tx_data sequence 30,31,32,33,30.
REQ-033 Wrap-around: the pointer at 3 after granting 2, req=4'b0101 -> requester 0 is granted next, then 2.
REQ-034 Gap: GAP_BITS=2 and tx_busy falling -> busy stays high until the 2nd subsequent b_tick, and no ack occurs before it.
REQ-035 Dropped request: req[1] raised during WAIT_DONE, then lowered before IDLE -> ack[1] is never asserted.
REQ-036 Reset mid-frame: rst pulsed in WAIT_DONE -> all outputs are 0 immediately; the next grant with req=4'b1010 goes to requester 1.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: arbiter FSM state encodings and default inter-frame gap shared by the UART TX slice.
package uart_pkg;
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LAUNCH    = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;
  localparam int GAP_BITS_DEF = 1;
endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// rr_select: combinational round-robin pick of the first set req bit at or after ptr, wrapping.
module rr_select #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);
  // Scan from the farthest offset down so the nearest requester is assigned last and wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int o = N - 1; o >= 0; o--) begin
      if (req[(int'(ptr) + o) % N]) begin
        valid = 1'b1;
        idx   = W'((int'(ptr) + o) % N);
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART serializer among N_REQ byte requesters.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int N_REQ    = 4,
  parameter  int GAP_BITS = GAP_BITS_DEF,
  localparam int W        = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             b_tick,
  input  logic [N_REQ-1:0] req,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic             tx_busy,
  output logic [N_REQ-1:0] ack,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic [W-1:0]     grant_id,
  output logic             busy
);
  localparam logic [3:0] GAP_LAST = 4'(GAP_BITS > 0 ? GAP_BITS - 1 : 0);
  logic [2:0]       state_q, state_d;
  logic [W-1:0]     ptr_q, ptr_d, grant_q, grant_d, sel_idx;
  logic [3:0]       gap_q, gap_d;
  logic [7:0]       data_q, data_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             start_q, start_d, sel_valid;
  rr_select #(.N(N_REQ), .W(W)) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .valid (sel_valid),
    .idx   (sel_idx)
  );
  wire grant = state_q == S_IDLE && sel_valid;
  always_comb begin
    state_d = state_q;
    ptr_d   = grant ? ((sel_idx == W'(N_REQ - 1)) ? '0 : sel_idx + W'(1)) : ptr_q;
    grant_d = grant ? sel_idx : grant_q;
    data_d  = grant ? req_data[8*sel_idx +: 8] : data_q;
    ack_d   = grant ? N_REQ'(1) << sel_idx : '0;
    start_d = state_q == S_LAUNCH;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE:      state_d = sel_valid ? S_LAUNCH : S_IDLE;
      S_LAUNCH:    state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: state_d = tx_busy ? S_WAIT_DONE : S_WAIT_BUSY;
      S_WAIT_DONE: begin
        state_d = tx_busy ? S_WAIT_DONE : S_GAP;
        gap_d   = '0;
      end
      S_GAP: begin
        state_d = (GAP_BITS == 0 || (b_tick && gap_q == GAP_LAST)) ? S_IDLE : S_GAP;
        gap_d   = b_tick ? gap_q + 4'd1 : gap_q;
      end
      default:     state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      gap_q   <= '0;
      data_q  <= '0;
      ack_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      start_q <= start_d;
    end
  end
  assign ack      = ack_q;
  assign tx_start = start_q;
  assign tx_data  = data_q;
  assign grant_id = grant_q;
  assign busy     = state_q != S_IDLE;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized round-robin traffic against a queue-based grant-order model with a serializer stub.
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int GAP = 2;
  typedef struct {int idx; logic [7:0] d;} exp_t;
  logic clk = 0, rst = 0, b_tick = 0, tx_busy = 0;
  logic [N-1:0] req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0] ack;
  logic tx_start, busy;
  logic [7:0] tx_data;
  logic [1:0] grant_id;
  int tests = 0, fails = 0, mp = 0;
  exp_t sb[$];
  logic [7:0] dat [N];
  uart_tx_arbiter #(.N_REQ(N), .GAP_BITS(GAP)) dut (
    .clk(clk), .rst(rst), .b_tick(b_tick), .req(req), .req_data(req_data),
    .tx_busy(tx_busy), .ack(ack), .tx_start(tx_start), .tx_data(tx_data),
    .grant_id(grant_id), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Scoreboard monitor: every ack pops one expected grant; tx_start must follow one cycle later.
  logic start_due = 0;
  logic [7:0] exp_d = 0, last_d = 0;
  always @(negedge clk) begin
    if (rst) begin
      start_due = 0;
      last_d = 0;
    end else begin
      if (start_due) begin
        chk("tx_start_after_ack", {tx_start, ack}, {1'b1, 4'b0});
        chk("tx_data_at_start", tx_data, exp_d);
        start_due = 0;
      end else if (tx_start) chk("unexpected_tx_start", 1, 0);
      if (ack != 0) begin
        if (sb.size() == 0) chk("unexpected_ack", ack, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_onehot", ack, 1 << e.idx);
          chk("grant_id", grant_id, e.idx);
          chk("tx_data_capture", tx_data, e.d);
          exp_d = e.d;
          start_due = 1;
        end
      end else if (tx_data != last_d) chk("tx_data_stable", tx_data, last_d);
      last_d = tx_data;
    end
  end
  // Serializer stub, baud ticks, and the post-frame gap check (busy must hold until the GAP-th tick).
  int left = 0, gap_phase = 0, ticks = 0;
  logic pend = 0, prev_b = 0;
  always @(negedge clk) begin
    if (rst) begin
      tx_busy = 0; pend = 0; gap_phase = 0; b_tick = 0; prev_b = 0;
    end else begin
      if (gap_phase == 2) begin
        if (prev_b) ticks++;
        if (ticks >= GAP) begin
          chk("gap_busy_low", busy, 0);
          gap_phase = 0;
        end else begin
          chk("gap_busy_high", busy, 1);
          chk("gap_no_ack", ack, 0);
        end
      end else if (gap_phase == 1) begin
        chk("gap_entry_busy", busy, 1);
        ticks = 0;
        gap_phase = 2;
      end
      if (pend) begin
        tx_busy = 1; pend = 0; left = $urandom_range(3, 8);
      end else if (tx_busy) begin
        if (left == 0) begin
          tx_busy = 0; gap_phase = 1;
        end else left--;
      end
      if (tx_start) pend = 1;
      b_tick = $urandom_range(0, 2) == 0;
      prev_b = b_tick;
    end
  end
  task automatic expect_grants(input logic [N-1:0] mask, input int n);
    int i = mp, pushed = 0;
    while (pushed < n) begin
      if (mask[i]) begin
        sb.push_back('{i, dat[i]});
        pushed++;
        mp = (i + 1) % N;
      end
      i = (i + 1) % N;
    end
  endtask
  task automatic wait_idle();
    int t = 0;
    while (busy && t < 400) begin @(negedge clk); t++; end
    if (t >= 400) chk("idle_timeout", busy, 0);
    @(negedge clk);
  endtask
  task automatic run(input logic [N-1:0] mask, input bit hold, input int n);
    int cnt = 0, t = 0;
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = dat[i];
    expect_grants(mask, n);
    req = mask;
    while (cnt < n && t < 200 * n) begin
      @(negedge clk); t++;
      for (int i = 0; i < N; i++) if (ack[i]) begin
        cnt++;
        if (!hold) req[i] = 0;
      end
      if (cnt >= n) req = '0;
    end
    if (cnt < n) chk("grant_timeout", cnt, n);
    req = '0;
    wait_idle();
  endtask
  task automatic wait_busy_high();
    int t = 0;
    while (!tx_busy && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("tx_busy_timeout", tx_busy, 1);
  endtask
  initial begin
    int ack1 = 0, t = 0;
    logic [N-1:0] m;
    #1 rst = 1;
    #1 chk("reset_outputs", {ack, tx_start, tx_data, grant_id, busy}, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < N; i++) dat[i] = 8'h30 + 8'(i);
    run(4'b1111, 1, 5);
    dat[2] = 8'h41;
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = dat[i];
    expect_grants(4'b0100, 1);
    req = 4'b0100;
    @(negedge clk);
    chk("latency_ack", ack, 4'b0100);
    req = '0;
    @(negedge clk);
    chk("latency_tx_start", tx_start, 1);
    chk("single_data", tx_data, 8'h41);
    chk("single_grant_id", grant_id, 2);
    wait_idle();
    run(4'b0101, 0, 2);
    dat[0] = 8'h5a;
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = dat[i];
    expect_grants(4'b0001, 1);
    req = 4'b0001;
    @(negedge clk);
    req = '0;
    wait_busy_high();
    @(negedge clk);
    req[1] = 1;
    while (tx_busy && t < 50) begin @(negedge clk); t++; if (ack[1]) ack1++; end
    req[1] = 0;
    wait_idle();
    repeat (5) begin @(negedge clk); if (ack[1]) ack1++; end
    chk("dropped_req_no_ack", ack1, 0);
    expect_grants(4'b0001, 1);
    req = 4'b0001;
    @(negedge clk);
    req = '0;
    wait_busy_high();
    repeat (2) @(negedge clk);
    #2 rst = 1;
    #1 chk("midframe_reset_outputs", {ack, tx_start, tx_data, grant_id, busy}, 0);
    mp = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    run(4'b1010, 0, 2);
    for (int r = 0; r < 25; r++) begin
      bit hold;
      int n;
      m = 4'($urandom_range(1, 15));
      hold = $urandom_range(0, 1) == 1;
      n = $countones(m) + (hold ? $urandom_range(0, 2) : 0);
      for (int i = 0; i < N; i++) dat[i] = 8'($urandom);
      run(m, hold, n);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
